nn_load_sequencer: RTL and testbench

//  Byte-serial load/evaluate controller for the 4x4 perceptron network. Accepts one byte

---
 rtl/nn_pkg.sv | 24 ++
 rtl/nn_wrap_counter.sv | 26 ++
 rtl/nn_load_sequencer.sv | 133 +++++++++++++
 tb/tb_nn_load_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared state encoding and parameter-layout constants for the perceptron loader
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_PRM = 3'd1,
    ST_LOAD_INP = 3'd2,
    ST_EVAL     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int N_NEURONS_DEF  = 4;
  localparam int N_INPUTS_DEF   = 4;
  localparam int PRM_PER_NEURON = N_INPUTS_DEF + 2;
  localparam int N_PRM_BYTES    = N_NEURONS_DEF * PRM_PER_NEURON;
  localparam int SLOT_BIAS      = 4;
  localparam int SLOT_TH        = 5;

  // Parameter bytes stream neuron-major, so the linear byte count is the address.
  function automatic int prm_addr_of(input int neuron, input int slot);
    return neuron * PRM_PER_NEURON + slot;
  endfunction

endpackage

// File: rtl/nn_wrap_counter.sv
// rtl/nn_wrap_counter.sv - up-counter 0..MAX with clear and a wrap flag on the terminal increment
module nn_wrap_counter #(
  parameter int W   = 5,
  parameter int MAX = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign wrap = inc & (count == MAX_V);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/nn_load_sequencer.sv
// rtl/nn_load_sequencer.sv - byte-stream parameter/input loader and evaluate strobe for the 4x4 perceptron
module nn_load_sequencer
  import nn_pkg::*;
#(
  parameter int N_NEURONS   = N_NEURONS_DEF,
  parameter int N_INPUTS    = N_INPUTS_DEF,
  parameter int DATA_W      = 8,
  parameter int EVAL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              skip_params,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              prm_we,
  output logic [4:0]        prm_addr,
  output logic [DATA_W-1:0] prm_data,
  output logic              inp_we,
  output logic [1:0]        inp_idx,
  output logic [DATA_W-1:0] inp_data,
  output logic              out_capture,
  output logic              busy,
  output logic              done,
  output logic [2:0]        phase
);

  localparam int N_PRM  = N_NEURONS * (N_INPUTS + 2);
  localparam int WAIT_W = $clog2(EVAL_CYCLES + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [4:0]        prm_cnt;
  logic [1:0]        inp_cnt;
  logic              prm_wrap, inp_wrap;
  logic              accept, abort_hit, prm_inc, inp_inc;

  assign accept    = in_valid & in_ready;
  assign abort_hit = abort & (state != ST_IDLE);
  assign prm_inc   = accept & (state == ST_LOAD_PRM) & ~abort;
  assign inp_inc   = accept & (state == ST_LOAD_INP) & ~abort;
  assign phase     = state;

  nn_wrap_counter #(.W(5), .MAX(N_PRM - 1)) u_prm_cnt (
    .clk(clk), .reset(reset), .clr(abort_hit), .inc(prm_inc),
    .count(prm_cnt), .wrap(prm_wrap)
  );

  nn_wrap_counter #(.W(2), .MAX(N_INPUTS - 1)) u_inp_cnt (
    .clk(clk), .reset(reset), .clr(abort_hit), .inc(inp_inc),
    .count(inp_cnt), .wrap(inp_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      in_ready    <= 1'b0;
      prm_we      <= 1'b0;
      prm_addr    <= '0;
      prm_data    <= '0;
      inp_we      <= 1'b0;
      inp_idx     <= '0;
      inp_data    <= '0;
      out_capture <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      prm_we      <= 1'b0;
      inp_we      <= 1'b0;
      out_capture <= 1'b0;
      done        <= 1'b0;
      // Abort drops any strobe that this edge would otherwise launch.
      if (abort_hit) begin
        state    <= ST_IDLE;
        wait_cnt <= '0;
        in_ready <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state    <= skip_params ? ST_LOAD_INP : ST_LOAD_PRM;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
          ST_LOAD_PRM: begin
            if (accept) begin
              prm_we   <= 1'b1;
              prm_addr <= prm_cnt;
              prm_data <= in_data;
              if (prm_wrap) state <= ST_LOAD_INP;
            end
          end
          ST_LOAD_INP: begin
            if (accept) begin
              inp_we   <= 1'b1;
              inp_idx  <= inp_cnt;
              inp_data <= in_data;
              if (inp_wrap) begin
                state    <= ST_EVAL;
                in_ready <= 1'b0;
                wait_cnt <= WAIT_W'(EVAL_CYCLES - 1);
              end
            end
          end
          ST_EVAL: begin
            if (wait_cnt == '0) begin
              out_capture <= 1'b1;
              state       <= ST_DONE;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            state    <= ST_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nn_load_sequencer.sv
// tb/tb_nn_load_sequencer.sv - directed self-checking bench for nn_load_sequencer (EVAL_CYCLES 2 and 5)
module tb_nn_load_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, skip_params, abort, in_valid;
  logic [7:0] in_data;

  logic       in_ready, prm_we, inp_we, out_capture, busy, done;
  logic [4:0] prm_addr;
  logic [7:0] prm_data, inp_data;
  logic [1:0] inp_idx;
  logic [2:0] phase;

  logic       in_ready5, prm_we5, inp_we5, out_capture5, busy5, done5;
  logic [4:0] prm_addr5;
  logic [7:0] prm_data5, inp_data5;
  logic [1:0] inp_idx5;
  logic [2:0] phase5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nn_load_sequencer #(.EVAL_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .skip_params(skip_params), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .prm_we(prm_we), .prm_addr(prm_addr), .prm_data(prm_data),
    .inp_we(inp_we), .inp_idx(inp_idx), .inp_data(inp_data),
    .out_capture(out_capture), .busy(busy), .done(done), .phase(phase)
  );

  nn_load_sequencer #(.EVAL_CYCLES(5)) dut5 (
    .clk(clk), .reset(reset), .start(start), .skip_params(skip_params), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready5),
    .prm_we(prm_we5), .prm_addr(prm_addr5), .prm_data(prm_data5),
    .inp_we(inp_we5), .inp_idx(inp_idx5), .inp_data(inp_data5),
    .out_capture(out_capture5), .busy(busy5), .done(done5), .phase(phase5)
  );

  int cyc = 0;
  int prm_a[$], prm_d[$], inp_i[$], inp_d[$];
  int last_inp_cyc, cap_cyc, done_cnt, last_inp5_cyc, cap5_cyc, done5_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prm_we) begin prm_a.push_back(int'(prm_addr)); prm_d.push_back(int'(prm_data)); end
    if (inp_we) begin inp_i.push_back(int'(inp_idx)); inp_d.push_back(int'(inp_data)); last_inp_cyc = cyc; end
    if (out_capture) cap_cyc = cyc;
    if (done) done_cnt++;
    if (inp_we5) last_inp5_cyc = cyc;
    if (out_capture5) cap5_cyc = cyc;
    if (done5) done5_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    prm_a.delete(); prm_d.delete(); inp_i.delete(); inp_d.delete();
    last_inp_cyc = -100; cap_cyc = -200; done_cnt = 0;
    last_inp5_cyc = -100; cap5_cyc = -200; done5_cnt = 0;
  endtask

  task automatic wait_quiet(input string tag);
    int k = 0;
    while ((busy || busy5) && k < 60) begin tick(); k++; end
    chk(tag, {30'd0, busy, busy5}, 32'd0);
    tick();
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1; in_data = b; tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; skip_params = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0;
    clear_logs();
    repeat (3) tick();
    chk("rst_phase", phase, 0);
    chk("rst_busy_ready", {busy, in_ready, done, out_capture}, 0);
    chk("rst_strobes", {prm_we, inp_we}, 0);
    chk("rst_data", {prm_addr, prm_data, inp_idx, inp_data}, 0);
    chk("rst_phase5", {phase5, busy5}, 0);
    reset = 1'b0;
    tick();

    // Full load, back-to-back bytes.
    clear_logs();
    start = 1'b1; skip_params = 1'b0; tick(); start = 1'b0;
    chk("t1_phase_prm", phase, 1);
    chk("t1_ready", in_ready, 1);
    for (int i = 0; i < 28; i++) send(8'(i));
    in_valid = 1'b0;
    wait_quiet("t1_timeout");
    chk("t1_prm_count", prm_a.size(), 24);
    for (int i = 0; i < 24; i++) begin
      if (i < prm_a.size()) begin
        chk("t1_prm_addr", prm_a[i], i);
        chk("t1_prm_data", prm_d[i], i);
      end
    end
    chk("t1_inp_count", inp_i.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < inp_i.size()) begin
        chk("t1_inp_idx", inp_i[i], i);
        chk("t1_inp_data", inp_d[i], 8'h18 + i);
      end
    end
    chk("t1_cap_lat", cap_cyc - last_inp_cyc, 2);
    chk("t1_done_lat", done_cyc_delta(), 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_cap5_lat", cap5_cyc - last_inp5_cyc, 5);
    chk("t1_busy_low", {busy, phase}, 0);

    // Gapped valid.
    clear_logs();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 28; i++) begin
      send(8'(i));
      in_valid = 1'b0; in_data = 8'hEE; tick();
    end
    wait_quiet("t2_timeout");
    chk("t2_prm_count", prm_a.size(), 24);
    for (int i = 0; i < 24; i++)
      if (i < prm_a.size()) chk("t2_prm_addr_data", {prm_a[i], prm_d[i]}, {i, i});
    chk("t2_inp_count", inp_i.size(), 4);
    if (inp_d.size() == 4) chk("t2_inp_last", {inp_i[3], inp_d[3]}, {32'd3, 32'h1B});
    chk("t2_done_cnt", done_cnt, 1);

    // Reuse stored parameters.
    clear_logs();
    start = 1'b1; skip_params = 1'b1; tick(); start = 1'b0; skip_params = 1'b0;
    chk("t3_phase_inp", phase, 2);
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
    in_valid = 1'b0;
    wait_quiet("t3_timeout");
    chk("t3_prm_none", prm_a.size(), 0);
    chk("t3_inp_count", inp_i.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < inp_i.size()) chk("t3_inp", {inp_i[i], inp_d[i]}, {i, 32'hA0 + i});
    chk("t3_done_cnt", done_cnt, 1);

    // Abort after the 10th parameter byte, with an 11th byte offered on the abort edge.
    clear_logs();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(i));
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h0A; tick(); abort = 1'b0;
    chk("t4_idle", {phase, busy, in_ready, prm_we}, 0);
    for (int i = 0; i < 3; i++) send(8'h40);
    chk("t4_idle_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (8) tick();
    chk("t4_prm_count", prm_a.size(), 10);
    if (prm_a.size() == 10) chk("t4_prm_last", {prm_a[9], prm_d[9]}, {32'd9, 32'd9});
    chk("t4_no_done", {done_cnt, cap_cyc}, {32'd0, -32'sd200});
    clear_logs();
    start = 1'b1; tick(); start = 1'b0;
    send(8'h55); in_valid = 1'b0; tick();
    chk("t4_restart_count", prm_a.size(), 1);
    if (prm_a.size() == 1) chk("t4_restart", {prm_a[0], prm_d[0]}, {32'd0, 32'h55});
    abort = 1'b1; tick(); abort = 1'b0;
    wait_quiet("t4_timeout");

    // Reset while the third input byte is offered.
    clear_logs();
    start = 1'b1; skip_params = 1'b1; tick(); start = 1'b0; skip_params = 1'b0;
    send(8'hC0); send(8'hC1);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hC2; tick();
    chk("t5_phase", phase, 0);
    chk("t5_outputs", {in_ready, inp_we, inp_idx, inp_data, busy, done, out_capture}, 0);
    reset = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    chk("t5_inp_count", inp_i.size(), 2);

    // Start during EVAL and bytes offered outside the load phases.
    clear_logs();
    start = 1'b1; skip_params = 1'b1; tick(); start = 1'b0; skip_params = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i));
    start = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    chk("t6_eval_state", {phase, in_ready}, {3'd3, 1'b0});
    tick(); start = 1'b0;
    chk("t6_eval_ready", in_ready, 0);
    in_valid = 1'b0;
    wait_quiet("t6_timeout");
    repeat (4) tick();
    chk("t6_inp_count", inp_i.size(), 4);
    chk("t6_done_cnt", {done_cnt, done5_cnt}, {32'd1, 32'd1});
    chk("t6_cap_lat", cap_cyc - last_inp_cyc, 2);
    chk("t6_cap5_lat", cap5_cyc - last_inp5_cyc, 5);
    for (int i = 0; i < 3; i++) send(8'h99);
    chk("t6_idle_ready", {in_ready, busy, phase}, 0);
    in_valid = 1'b0; tick();
    chk("t6_idle_ignored", {prm_a.size(), inp_i.size()}, {32'd0, 32'd4});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  int done_cyc_q;
  always @(negedge clk) if (done) done_cyc_q = cyc;

  function automatic int done_cyc_delta();
    return done_cyc_q - cap_cyc;
  endfunction

endmodule
